prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, 14'h0000, RAM byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, 4096, maximum accepted word count (16 KB RAM).
REQ-003 SHALL have clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have in_data  input  8  program stream byte.
REQ-006 SHALL have in_valid  input  1  in_data valid.
REQ-007 SHALL have in_ready  output  1  loader can accept a byte.
REQ-008 SHALL have wr_en  output  1  RAM word-write strobe (32-bit write).
REQ-009 SHALL have wr_addr  output  14  RAM byte address; bits[1:0] always 0.
REQ-010 SHALL have wr_data  output  32  RAM write word.
REQ-011 SHALL have cpu_resetn  output  1  core release; 0 holds the core in reset.
REQ-012 SHALL have done  output  1  program loaded and checksum good.
REQ-013 SHALL have error  output  1  load failed (length or checksum).
REQ-014 SHALL have word_count  output  13  words written so far.

Function
REQ-015 SHALL accept a byte on every rising edge where in_valid && in_ready; in_ready derived from state only, never from in_valid.
REQ-016 SHALL parse frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N data bytes, one checksum byte.
REQ-017 SHALL place data byte k (0..3) of each word at wr_data[8k+7:8k] (little-endian, matches fetch order).
REQ-018 SHALL define checksum as XOR of all 4*N data bytes only; length bytes excluded; N=0 expects 8'h00.
REQ-019 SHALL implement states S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR; in_ready=1 only in the first four.
REQ-020 SHALL transition LEN_LO->LEN_HI on accept; LEN_HI->DATA if 0<N<=MAX_WORDS, ->CSUM if N=0, ->ERR if N>MAX_WORDS.
REQ-021 SHALL stay in DATA until the 4th byte of word N-1 is accepted, then go to CSUM.
REQ-022 SHALL on checksum accept go to S_RUN if match, else S_ERR.
REQ-023 SHALL pulse wr_en for exactly one cycle, registered, in the cycle after each word's 4th byte is accepted; wr_data/wr_addr valid in that cycle.
REQ-024 SHALL drive wr_addr = BASE_ADDR + 4*word_index, wrapping modulo 2^14.
REQ-025 SHALL increment word_count in the same cycle wr_en is high.
REQ-026 SHALL in S_RUN drive done=1 and cpu_resetn=1, both rising the cycle after the checksum byte is accepted.
REQ-027 SHALL in S_ERR drive error=1 (cycle after the offending byte), cpu_resetn=0, no further wr_en.
REQ-028 SHALL treat S_RUN and S_ERR as terminal until resetn is asserted.
REQ-029 SHALL hold state, partial word and checksum unchanged through any number of in_valid=0 cycles.
REQ-030 SHALL never have cpu_resetn=1 in a cycle where wr_en=1 or a write is pending.

Reset
REQ-031 SHALL on resetn=0 at a clock edge set: state S_LEN_LO, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_resetn=0, done=0, error=0, word_count=0, checksum and byte index 0.
REQ-032 SHALL drive in_ready=0 while resetn=0.
REQ-033 SHALL on reset mid-frame discard the partial word; words already written stay in RAM and are not rewritten.

Verification
REQ-034 Bytes 02 00 | 13 05 00 00 | 73 00 10 00 | 75 -> wr 0x00000513 @0x0000, 0x00100073 @0x0004, word_count=2, done=1 and cpu_resetn=1 one cycle after 0x75 accepted.
REQ-035 Same frame with checksum 0x74 -> both writes occur, error=1, cpu_resetn stays 0, in_ready=0 thereafter.
REQ-036 Length bytes 01 10 (N=4097) -> error=1 next cycle, zero wr_en pulses, later in_valid bytes not accepted.
REQ-037 Bytes 00 00 00 -> done=1, no writes; bytes 00 00 01 -> error=1.
REQ-038 Frame of REQ-034 with in_valid low every other cycle and random 0-5 cycle gaps -> identical write sequence and result.
REQ-039 resetn low after 6 data bytes of REQ-034, then full REQ-034 frame -> writes restart at BASE_ADDR, word_count counts 1,2 from 0, done=1.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed byte stream into 32-bit
// RAM words, verifies an XOR checksum, then releases the core from reset.
module prog_loader #(
    parameter logic [13:0] BASE_ADDR = 14'h0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_resetn,
    output logic        done,
    output logic        error,
    output logic [12:0] word_count
);

    typedef enum logic [2:0] {
        S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] part_q, part_d;
    logic [7:0]  csum_q, csum_d;
    logic        wr_en_q, wr_en_d;
    logic [13:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [12:0] word_count_q, word_count_d;

    logic        accept;
    logic [15:0] len_in;

    always_comb begin
        in_ready     = resetn && (state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM});
        accept       = in_valid && in_ready;
        len_in       = {in_data, len_lo_q};
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        byte_idx_d   = byte_idx_q;
        part_d       = part_q;
        csum_d       = csum_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;

        case (state_q)
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_in;
                    if (len_in == 16'd0)
                        state_d = S_CSUM;
                    else if ({1'b0, len_in} > MAX_N)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Bytes arrive LSB first, so the partial word is a right shifter
                        wr_en_d      = 1'b1;
                        wr_data_d    = {in_data, part_q};
                        wr_addr_d    = BASE_ADDR + {word_count_q[11:0], 2'b00};
                        word_count_d = word_count_q + 13'd1;
                        part_d       = 24'd0;
                        if (({3'b000, word_count_q} + 16'd1) == len_q)
                            state_d = S_CSUM;
                    end else begin
                        part_d = {in_data, part_q[23:8]};
                    end
                end
            end
            S_CSUM: begin
                if (accept)
                    state_d = (in_data == csum_q) ? S_RUN : S_ERR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_LEN_LO;
            len_lo_q     <= 8'd0;
            len_q        <= 16'd0;
            byte_idx_q   <= 2'd0;
            part_q       <= 24'd0;
            csum_q       <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= 32'd0;
            word_count_q <= 13'd0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            byte_idx_q   <= byte_idx_d;
            part_q       <= part_d;
            csum_q       <= csum_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
        end
    end

    // The last write always retires before the checksum can move us to S_RUN
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;
    assign done       = (state_q == S_RUN);
    assign cpu_resetn = (state_q == S_RUN);
    assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level reference model predicts the
// writes and final outcome; a monitor checks every write strobe as it appears.
module tb_prog_loader;

    localparam logic [13:0] BASE = 14'h0000;
    localparam int          MAXW = 4096;

    typedef logic [7:0] u8;
    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
        logic [12:0] cnt;
    } wr_t;

    logic        clk;
    logic        resetn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_resetn;
    logic        done;
    logic        error;
    logic [12:0] word_count;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_resetn(cpu_resetn), .done(done), .error(error), .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", wr_data, e.data);
                chk("word_count_at_write", 32'(word_count), 32'(e.cnt));
                chk("cpu_resetn_during_write", 32'(cpu_resetn), 32'd0);
            end
        end
    end

    // Reference model: parse the byte list as a frame.
    // res: 0 = frame incomplete, 1 = loaded OK, 2 = error. n_acc = bytes the loader takes.
    task automatic model(input u8 b[$], output int n_acc, output int res, output int nw);
        int  n;
        u8   cs;
        wr_t w;
        res = 0;
        nw  = 0;
        if (b.size() < 2) begin
            n_acc = b.size();
            return;
        end
        n = int'(b[0]) + 256 * int'(b[1]);
        if (n > MAXW) begin
            n_acc = 2;
            res   = 2;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (b.size() >= 2 + 4 * k + 4) begin
                w.addr = 14'((int'(BASE) + 4 * k) % 16384);
                w.data = {b[2+4*k+3], b[2+4*k+2], b[2+4*k+1], b[2+4*k]};
                w.cnt  = 13'(k + 1);
                exp_q.push_back(w);
                nw++;
            end
        end
        if (b.size() >= 3 + 4 * n) begin
            cs = 8'h00;
            for (int j = 0; j < 4 * n; j++) cs = cs ^ b[2+j];
            res   = (b[2+4*n] == cs) ? 1 : 2;
            n_acc = 3 + 4 * n;
        end else begin
            n_acc = b.size();
        end
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'(BASE));
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input u8 b[$], input bit gaps);
        int n_acc, res, nw, wait_c, extra;
        do_reset();
        model(b, n_acc, res, nw);
        for (int i = 0; i < n_acc; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = b[i];
            wait_c   = 0;
            @(negedge clk);
            while (!in_ready && wait_c < 20) begin
                wait_c++;
                @(negedge clk);
            end
            if (!in_ready) begin
                chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            if (i == n_acc - 1) begin
                chk({tag, "_done_early"}, 32'(done), 32'd0);
                chk({tag, "_error_early"}, 32'(error), 32'd0);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'(res == 1));
        chk({tag, "_error"}, 32'(error), 32'(res == 2));
        chk({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'(res == 1));
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'(res == 0));
        if (res == 1) chk({tag, "_word_count_final"}, 32'(word_count), 32'(nw));
        @(posedge clk);
        #1;
        extra = 0;
        for (int i = n_acc; i < b.size() && extra < 3; i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            @(negedge clk);
            chk({tag, "_late_byte_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            extra++;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_writes_outstanding"}, 32'(exp_q.size()), 32'd0);
        if (res != 0) chk({tag, "_terminal_hold"}, {30'd0, error, done}, {30'd0, res == 2, res == 1});
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        u8  q[$];
        int n;
        u8  cs;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        q = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00, 8'h75};
        run_frame("good2", q, 1'b0);
        q = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00, 8'h74};
        run_frame("badcsum", q, 1'b0);
        q = {8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
        run_frame("toolong", q, 1'b0);
        q = {8'h00, 8'h00, 8'h00};
        run_frame("empty_ok", q, 1'b0);
        q = {8'h00, 8'h00, 8'h01};
        run_frame("empty_bad", q, 1'b0);
        q = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00, 8'h75};
        run_frame("gapped", q, 1'b1);
        q = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h73, 8'h00};
        run_frame("partial", q, 1'b0);
        q = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00, 8'h75};
        run_frame("after_abort", q, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n  = $urandom_range(0, 6);
            q  = {8'(n), 8'h00};
            cs = 8'h00;
            for (int j = 0; j < 4 * n; j++) begin
                q.push_back(8'($urandom));
                cs = cs ^ q[q.size()-1];
            end
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            q.push_back(cs);
            q.push_back(8'($urandom));
            run_frame("random", q, 1'($urandom_range(0, 1)));
        end

        q  = {8'h00, 8'h10};
        cs = 8'h00;
        for (int j = 0; j < 4 * MAXW; j++) begin
            q.push_back(8'($urandom));
            cs = cs ^ q[q.size()-1];
        end
        q.push_back(cs);
        run_frame("max_len", q, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
